// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, fetch state encoding and PC helpers for the IF stage
package if_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALLED = 2'd1,
        DRAIN   = 2'd2
    } fetch_state_t;

    // Redirect targets are forced word-aligned; there is no misalignment trap.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~WORD_W'(3);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/response bundle between IF stage and imem
interface if_stage_if;
    import if_stage_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ready;
    logic [WORD_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with enable, flush-to-NOP and sync reset
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [WORD_W-1:0] instr_d,
    input  logic [WORD_W-1:0] pc_d,
    output logic [WORD_W-1:0] instr_q,
    output logic [WORD_W-1:0] pc_q
);

    // A flush only replaces the instruction; the PC field keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (flush) begin
            instr_q <= NOP_INSTR;
        end else if (en) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-V instruction fetch stage: PC, imem handshake FSM and IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IFWrite,
    input  logic              Branch,
    input  logic              Jump,
    input  logic [WORD_W-1:0] JumpAddr,
    if_stage_if.master        bus,
    output logic [WORD_W-1:0] Instruction_id,
    output logic [WORD_W-1:0] PC_id
);

    fetch_state_t      state, state_n;
    logic [WORD_W-1:0] pc, pc_n;
    logic [WORD_W-1:0] redir_pc, redir_pc_n;
    logic [WORD_W-1:0] buf_word, buf_word_n;
    logic              ifid_en, ifid_flush;
    logic [WORD_W-1:0] ifid_instr;
    logic              redirect;

    // A stall outranks a redirect: decode re-evaluates the branch with fresh operands.
    assign redirect = (Branch | Jump) & IFWrite;

    assign bus.imem_addr = pc;
    assign bus.imem_req  = ~reset & (state != STALLED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            redir_pc <= '0;
            buf_word <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            redir_pc <= redir_pc_n;
            buf_word <= buf_word_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        redir_pc_n = redir_pc;
        buf_word_n = buf_word;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        ifid_instr = bus.imem_rdata;
        case (state)
            FETCH: begin
                if (bus.imem_ready) begin
                    if (redirect) begin
                        ifid_flush = 1'b1;
                        pc_n       = align_word(JumpAddr);
                    end else if (IFWrite) begin
                        ifid_en = 1'b1;
                        pc_n    = pc + WORD_W'(4);
                    end else begin
                        buf_word_n = bus.imem_rdata;
                        state_n    = STALLED;
                    end
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    redir_pc_n = JumpAddr;
                    state_n    = DRAIN;
                end else if (IFWrite) begin
                    ifid_flush = 1'b1;
                end
            end
            STALLED: begin
                if (IFWrite) begin
                    state_n = FETCH;
                    if (redirect) begin
                        ifid_flush = 1'b1;
                        pc_n       = align_word(JumpAddr);
                    end else begin
                        ifid_en    = 1'b1;
                        ifid_instr = buf_word;
                        pc_n       = pc + WORD_W'(4);
                    end
                end
            end
            DRAIN: begin
                // The stale response is dropped; IF/ID already holds the NOP from entry.
                if (bus.imem_ready) begin
                    pc_n    = align_word(redir_pc);
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    if_stage_if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (ifid_en),
        .flush   (ifid_flush),
        .instr_d (ifid_instr),
        .pc_d    (pc),
        .instr_q (Instruction_id),
        .pc_q    (PC_id)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with directed scenarios and a random model run
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IFWrite = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] JumpAddr = '0;
    logic        ready_drv = 1'b0;
    logic        mem_mode = 1'b0;
    logic [31:0] Instruction_id, PC_id;

    int vectors = 0;
    int miscompares = 0;

    // reference model: architectural PC, IF/ID contents, plus at most one parked word or pending target
    logic [31:0] m_pc, m_instr, m_pcid;
    logic [31:0] buf_q[$];
    logic [31:0] drain_q[$];

    logic        got_req, exp_req;
    logic [31:0] got_addr, exp_addr;

    if_stage_if bus();

    assign bus.imem_ready = ready_drv;
    assign bus.imem_rdata = mem_mode ? (bus.imem_addr ^ 32'hA5A5_0013) : 32'h0000_0093;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .bus            (bus),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_mode ? (a ^ 32'hA5A5_0013) : 32'h0000_0093;
    endfunction

    task automatic cycle(input logic rst, input logic ifw, input logic br, input logic jp,
                         input logic [31:0] ja, input logic rdy);
        logic [31:0] word;
        reset = rst; IFWrite = ifw; Branch = br; Jump = jp; JumpAddr = ja; ready_drv = rdy;
        #1;
        got_req  = bus.imem_req;
        got_addr = bus.imem_addr;
        exp_req  = !rst && (buf_q.size() == 0);
        exp_addr = m_pc;
        word = mem_word(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_pcid = 32'h0;
            buf_q.delete(); drain_q.delete();
        end else if (drain_q.size() != 0) begin
            if (rdy) m_pc = drain_q.pop_front() & ~32'h3;
        end else if (buf_q.size() != 0) begin
            if (ifw) begin
                if (br || jp) begin
                    m_instr = NOP; m_pc = ja & ~32'h3; buf_q.delete();
                end else begin
                    m_instr = buf_q.pop_front(); m_pcid = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end else if (ifw && (br || jp)) begin
            m_instr = NOP;
            if (rdy) m_pc = ja & ~32'h3;
            else drain_q.push_back(ja);
        end else if (ifw) begin
            if (rdy) begin m_instr = word; m_pcid = m_pc; m_pc = m_pc + 32'd4; end
            else m_instr = NOP;
        end else if (rdy) begin
            buf_q.push_back(word);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 32'h0, 0);
        vectors++; if (got_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", got_req); end
        cycle(1, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_req !== 1'b0) begin miscompares++; $display("FAIL reset_req2: got %b want 0", got_req); end
        vectors++; if (Instruction_id !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h want %h", Instruction_id, NOP); end
        vectors++; if (PC_id !== 32'h0) begin miscompares++; $display("FAIL reset_pcid: got %h want 0", PC_id); end
    endtask

    task automatic test_stream();
        mem_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0, 32'h0, 1);
            vectors++; if (got_req !== 1'b1 || got_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_addr: got %b/%h want 1/%h", got_req, got_addr, 32'(i * 4)); end
            vectors++; if (PC_id !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_pcid: got %h want %h", PC_id, 32'(i * 4)); end
            vectors++; if (Instruction_id !== 32'h93) begin miscompares++; $display("FAIL stream_instr: got %h want 00000093", Instruction_id); end
        end
    endtask

    task automatic test_stall();
        mem_mode = 1'b1;
        cycle(0, 0, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'h8) begin miscompares++; $display("FAIL stall_addr: got %h want 00000008", got_addr); end
        vectors++; if (PC_id !== 32'h4 || Instruction_id !== 32'h93) begin miscompares++; $display("FAIL stall_hold1: got %h/%h want 00000004/00000093", PC_id, Instruction_id); end
        cycle(0, 0, 0, 0, 32'h0, 1);
        vectors++; if (got_req !== 1'b0) begin miscompares++; $display("FAIL stall_req: got %b want 0", got_req); end
        vectors++; if (PC_id !== 32'h4) begin miscompares++; $display("FAIL stall_hold2: got %h want 00000004", PC_id); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_req !== 1'b0) begin miscompares++; $display("FAIL stall_release_req: got %b want 0", got_req); end
        vectors++; if (PC_id !== 32'h8 || Instruction_id !== (32'h8 ^ 32'hA5A5_0013)) begin miscompares++; $display("FAIL stall_release: got %h/%h want 00000008/%h", PC_id, Instruction_id, 32'h8 ^ 32'hA5A5_0013); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_req !== 1'b1 || got_addr !== 32'hC) begin miscompares++; $display("FAIL stall_next: got %b/%h want 1/0000000c", got_req, got_addr); end
    endtask

    task automatic test_redirect_ready();
        cycle(0, 1, 0, 1, 32'h100, 1);
        vectors++; if (got_addr !== 32'h10) begin miscompares++; $display("FAIL jump_from: got %h want 00000010", got_addr); end
        vectors++; if (Instruction_id !== NOP || PC_id !== 32'hC) begin miscompares++; $display("FAIL jump_bubble: got %h/%h want %h/0000000c", Instruction_id, PC_id, NOP); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'h100) begin miscompares++; $display("FAIL jump_target: got %h want 00000100", got_addr); end
        vectors++; if (PC_id !== 32'h100) begin miscompares++; $display("FAIL jump_pcid: got %h want 00000100", PC_id); end
    endtask

    task automatic test_redirect_slow();
        cycle(0, 1, 1, 0, 32'h40, 0);
        vectors++; if (got_addr !== 32'h104) begin miscompares++; $display("FAIL drain_start: got %h want 00000104", got_addr); end
        vectors++; if (Instruction_id !== NOP) begin miscompares++; $display("FAIL drain_nop0: got %h want %h", Instruction_id, NOP); end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0);
            vectors++; if (got_req !== 1'b1 || got_addr !== 32'h104) begin miscompares++; $display("FAIL drain_hold: got %b/%h want 1/00000104", got_req, got_addr); end
            vectors++; if (Instruction_id !== NOP) begin miscompares++; $display("FAIL drain_nop: got %h want %h", Instruction_id, NOP); end
        end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'h104) begin miscompares++; $display("FAIL drain_ready_addr: got %h want 00000104", got_addr); end
        vectors++; if (Instruction_id !== NOP || PC_id !== 32'h100) begin miscompares++; $display("FAIL drain_discard: got %h/%h want %h/00000100", Instruction_id, PC_id, NOP); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'h40) begin miscompares++; $display("FAIL drain_target: got %h want 00000040", got_addr); end
        vectors++; if (PC_id !== 32'h40) begin miscompares++; $display("FAIL drain_pcid: got %h want 00000040", PC_id); end
    endtask

    task automatic test_stall_branch();
        cycle(0, 0, 1, 0, 32'h200, 1);
        vectors++; if (got_addr !== 32'h44) begin miscompares++; $display("FAIL sb_addr: got %h want 00000044", got_addr); end
        vectors++; if (PC_id !== 32'h40 || Instruction_id !== (32'h40 ^ 32'hA5A5_0013)) begin miscompares++; $display("FAIL sb_hold: got %h/%h want 00000040/%h", PC_id, Instruction_id, 32'h40 ^ 32'hA5A5_0013); end
        cycle(0, 1, 1, 0, 32'h200, 1);
        vectors++; if (got_req !== 1'b0 || got_addr !== 32'h44) begin miscompares++; $display("FAIL sb_pc_held: got %b/%h want 0/00000044", got_req, got_addr); end
        vectors++; if (Instruction_id !== NOP || PC_id !== 32'h40) begin miscompares++; $display("FAIL sb_flush: got %h/%h want %h/00000040", Instruction_id, PC_id, NOP); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'h200) begin miscompares++; $display("FAIL sb_target: got %h want 00000200", got_addr); end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 0, 1, 32'hFFFF_FFFF, 1);
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_align: got %h want fffffffc", got_addr); end
        vectors++; if (PC_id !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pcid: got %h want fffffffc", PC_id); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 00000000", got_addr); end
    endtask

    task automatic test_reset_drain();
        cycle(0, 1, 1, 0, 32'h80, 0);
        cycle(0, 1, 0, 0, 32'h0, 0);
        vectors++; if (got_req !== 1'b1 || got_addr !== 32'h4) begin miscompares++; $display("FAIL rd_drain: got %b/%h want 1/00000004", got_req, got_addr); end
        cycle(1, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_req !== 1'b0) begin miscompares++; $display("FAIL rd_req: got %b want 0", got_req); end
        vectors++; if (Instruction_id !== NOP || PC_id !== 32'h0) begin miscompares++; $display("FAIL rd_ifid: got %h/%h want %h/00000000", Instruction_id, PC_id, NOP); end
        cycle(0, 1, 0, 0, 32'h0, 1);
        vectors++; if (got_req !== 1'b1 || got_addr !== 32'h0) begin miscompares++; $display("FAIL rd_pc: got %b/%h want 1/00000000", got_req, got_addr); end
    endtask

    task automatic test_random();
        logic rst, ifw, br, jp, rdy;
        mem_mode = 1'b1;
        cycle(1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            ifw = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 7) == 0);
            jp  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            cycle(rst, ifw, br, jp, $urandom, rdy);
            vectors++; if (got_req !== exp_req) begin miscompares++; $display("FAIL rnd_req @%0d: got %b want %b", i, got_req, exp_req); end
            vectors++; if (got_addr !== exp_addr) begin miscompares++; $display("FAIL rnd_addr @%0d: got %h want %h", i, got_addr, exp_addr); end
            vectors++; if (Instruction_id !== m_instr) begin miscompares++; $display("FAIL rnd_instr @%0d: got %h want %h", i, Instruction_id, m_instr); end
            vectors++; if (PC_id !== m_pcid) begin miscompares++; $display("FAIL rnd_pcid @%0d: got %h want %h", i, PC_id, m_pcid); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_ready();
        test_redirect_slow();
        test_stall_branch();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. It is the producer side of the IF/ID interface that the decode stage consumes.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register that drives Instruction_id / PC_id.
- Consumes the decode stage's hazard and redirect outputs: IFWrite, Branch, Jump, JumpAddr.
- Inserts NOP bubbles on taken redirects and when instruction memory is slow.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), value used for flushes and bubbles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IFWrite  in  1  from decode; 0 means hold the IF/ID register and the PC (load-use stall).
- Branch  in  1  from decode; taken conditional branch in the decode stage.
- Jump  in  1  from decode; JAL/JALR in the decode stage.
- JumpAddr  in  32  from decode; redirect target, valid when Branch|Jump.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory has accepted the request; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- Instruction_id  out  32  IF/ID register, instruction field.
- PC_id  out  32  IF/ID register, PC of Instruction_id.

Behaviour:
- Reset (synchronous, active-high):
  - PC <= RESET_PC; state <= FETCH.
  - Instruction_id <= NOP_INSTR; PC_id <= 0; redir_pc <= 0; buf <= 0.
  - imem_req = 0 in any cycle where reset=1.
  - Reset asserted mid-request abandons the request; the memory must tolerate a dropped request.
- Definitions:
  - redirect = (Branch|Jump) & IFWrite.
  - A stall (IFWrite=0) overrides Branch/Jump: the decode instruction is re-evaluated next cycle with correct operands.
- imem handshake:
  - Single outstanding request.
  - imem_addr = PC in both FETCH and DRAIN.
  - imem_req=1 in FETCH and DRAIN, 0 in STALLED.
  - Address and req stay stable until imem_ready=1; zero-wait memories may assert ready in the same cycle.
- FETCH:
  - ready & redirect: IF/ID <= {NOP_INSTR, PC_id unchanged}; PC <= JumpAddr; fetched word discarded; stay FETCH.
  - !ready & redirect: IF/ID <= NOP; redir_pc <= JumpAddr; go DRAIN.
  - ready & IFWrite: Instruction_id <= imem_rdata; PC_id <= PC; PC <= PC+4.
  - ready & !IFWrite: buf <= imem_rdata; IF/ID held; go STALLED.
  - !ready & IFWrite: IF/ID <= NOP (bubble, PC_id unchanged); PC held.
  - !ready & !IFWrite: IF/ID held; PC held.
- STALLED (word buffered, no request):
  - !IFWrite: hold everything.
  - IFWrite & !redirect: Instruction_id <= buf; PC_id <= PC; PC <= PC+4; go FETCH.
  - IFWrite & redirect: IF/ID <= NOP; PC <= JumpAddr; buf discarded; go FETCH.
- DRAIN (old request still outstanding):
  - IF/ID holds NOP; IFWrite, Branch and Jump are ignored.
  - On ready: discard the data; PC <= redir_pc; go FETCH.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Alignment: bits [1:0] of JumpAddr are forced to 0 when loaded into PC (no misalignment trap).
- Throughput: 1 instruction/cycle with a zero-wait memory and no hazards.
- Taken-redirect penalty: one bubble, plus drain cycles if a request is outstanding.

Decomposition:
- Shared package:
  - NOP_INSTR and RESET_PC defaults.
  - The fetch state enum {FETCH, STALLED, DRAIN} (2-bit encoding).
  - The 32-bit word width constant, reused by the decode stage and the IF/ID interface.
- One sub-module: if_id_reg, the 64-bit IF/ID pipeline register with enable (IFWrite), flush (load NOP) and synchronous reset.
- The PC/next-PC logic and the FSM stay in if_stage.

Test Plan:
1. Reset, zero-wait imem returning 32'h0000_0093 for every address:
   - imem_addr = 0, 4, 8 on successive cycles.
   - PC_id = 0, 4, 8 one cycle later.
   - Instruction_id = 32'h0000_0093 from the first cycle after reset.
2. Stall: hold IFWrite=0 for 2 cycles while PC=8 and ready=1:
   - Instruction_id/PC_id frozen at PC_id=4; state STALLED; imem_req=0.
   - After release: PC_id=8 with the buffered word; the next fetch is 12.
3. Redirect with ready: Jump=1, JumpAddr=32'h0000_0100 at PC=16:
   - Next Instruction_id = 32'h0000_0013.
   - Next imem_addr = 32'h100.
   - The following cycle PC_id = 32'h100.
4. Redirect with imem_ready low for 3 cycles, Branch=1, JumpAddr=32'h40:
   - imem_addr stays at the old PC until ready.
   - IF/ID = NOP throughout; that data is discarded.
   - Then imem_addr = 32'h40.
5. Branch=1 together with IFWrite=0:
   - No redirect; PC and IF/ID unchanged.
   - The next cycle with IFWrite=1 and Branch=1 performs the redirect.
6. PC=32'hFFFF_FFFC with a ready fetch:
   - Next imem_addr = 0.
   - Reset asserted during a DRAIN returns PC to RESET_PC and Instruction_id to NOP next cycle.
